// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with valid/ready handshakes.
// Emits a single one-hot beat or a walking-one sweep from bit 0 to the index.
module onehot_dec #(
  parameter int W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_idx,
  input  logic              in_sweep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(1<<W)-1:0] out_deg,
  output logic [W-1:0]      out_idx,
  output logic              out_last
);

  localparam int N = 1 << W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] INC = {{(W-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [W-1:0]   tgt_q,   tgt_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   deg_q,   deg_d;
  logic [W-1:0]   idx_q,   idx_d;
  logic           last_q,  last_d;

  logic           req_acc;
  logic           beat_acc;
  logic [W-1:0]   idx_nx;

  assign in_ready = (state_q == IDLE);
  assign req_acc  = in_valid && in_ready;
  assign beat_acc = valid_q && out_ready;
  assign idx_nx   = idx_q + INC;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    deg_d   = deg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_acc) begin
          tgt_d   = in_idx;
          valid_d = 1'b1;
          state_d = SEND;
          if (in_sweep) begin
            idx_d  = '0;
            deg_d  = ONE;
            last_d = (in_idx == '0);
          end else begin
            idx_d  = in_idx;
            deg_d  = ONE << in_idx;
            last_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (beat_acc) begin
          if (last_q) begin
            // deg/idx keep their last values once the transaction ends
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            deg_d  = deg_q << 1;
            idx_d  = idx_nx;
            last_d = (idx_nx == tgt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      deg_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      deg_q   <= deg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_deg   = deg_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: doc/onehot_dec.md
# onehot_dec

Binary-to-one-hot decoder with valid/ready handshakes; the inverse of the team's one-hot-to-log2 encoder. It accepts a binary index and emits the matching one-hot word, either as a single beat or as a walking-one sweep from bit 0 up to the indexed bit. It sits upstream of the encoder in loopback and self-test paths, so every beat it emits must round-trip through the encoder back to `out_idx`.

## Interface

- `W`, default 3: index width. Output word width is `N = 2**W`. Legal range is 1..5.
- `clk`, input, 1: clock. Everything is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
- `in_idx`, input, W: target bit index.
- `in_sweep`, input, 1: 0 selects a single beat, 1 selects a walking-one sweep from bit 0 to `in_idx`.
- `out_valid`, output, 1: output beat present.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_deg`, output, N: one-hot word.
- `out_idx`, output, W: binary index of the set bit in `out_deg`.
- `out_last`, output, 1: marks the final beat of the transaction.

## Operation

- FSM with two states: IDLE and SEND.
- Reset, while `rst` is high and on exit: state IDLE, `out_valid` 0, `out_deg` 0, `out_idx` 0, `out_last` 0, internal target register 0. Inputs are ignored while `rst` is high.
- `in_ready` = (state == IDLE), combinational from the state register. It is 1 during and after reset.
- Request accept: `in_valid && in_ready` at a rising edge.
  - Target register <= `in_idx`.
  - Single beat (`in_sweep` = 0): `out_idx` <= `in_idx`, `out_deg` <= 1 << `in_idx`, `out_last` <= 1.
  - Sweep (`in_sweep` = 1): `out_idx` <= 0, `out_deg` <= 1, `out_last` <= (`in_idx` == 0).
  - In both modes: `out_valid` <= 1, state <= SEND.
- Beat accept: `out_valid && out_ready` at a rising edge.
  - If `out_last` = 1: `out_valid` <= 0, `out_last` <= 0, state <= IDLE. `out_deg` and `out_idx` keep their last values; they are don't-care while `out_valid` = 0.
  - Otherwise: `out_deg` <= `out_deg` << 1, `out_idx` <= `out_idx` + 1, `out_last` <= (`out_idx` + 1 == target).
- Stall: while `out_valid` = 1 and `out_ready` = 0, `out_deg`, `out_idx` and `out_last` hold exactly.
- Invariant: whenever `out_valid` = 1, `out_deg` == 1 << `out_idx`, and `out_deg` has exactly one bit set.
- Beat count: a sweep to index k emits exactly k+1 beats with indices 0..k. A single-beat request emits 1 beat.
- `out_idx` never exceeds the target, so there is no wrap. An index of N-1 sets the MSB and the transaction ends there.
- While in SEND, `in_valid` and `in_sweep` are ignored; the requester holds its request until `in_ready` returns.

## Timing

- Request accepted at edge t: first beat valid after edge t, i.e. visible in cycle t+1.
- Beat accepted at edge t: next beat is valid in cycle t+1 when `out_ready` is held high, so a sweep to k takes k+1 cycles with no stalls.
- Final beat accepted at edge t: `in_ready` = 1 in cycle t+1, and the next request can be accepted at edge t+1. The minimum request period is (beats + 1) cycles.
- There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). The partial transaction is dropped, and the block is in IDLE on the first edge after `rst` falls.

## Test plan

- Single beats: for each index 0..7 with `in_sweep` = 0 and `out_ready` = 1 → one beat per request, `out_deg` = 8'h01, 8'h02, … 8'h80, `out_idx` = index, `out_last` = 1; `in_ready` low for exactly one cycle after each accept.
- Sweep to index 7 with `out_ready` = 1 → 8 consecutive beats, `out_deg` 8'h01 → 8'h80, `out_idx` 0 → 7, `out_last` only on the 8'h80 beat; `in_ready` returns 1 cycle after that beat.
- Sweep to index 0 → a single beat `out_deg` = 8'h01 with `out_last` = 1, identical to a single-beat request for index 0.
- Sweep to index 4 with `out_ready` toggling at random → exactly 5 beats (8'h01, 02, 04, 08, 10); outputs stable across every stall cycle; requests on `in_valid` during the sweep are not accepted.
- `rst` pulsed during a sweep to index 6 at beat 3 → `out_valid`, `out_deg`, `out_idx` and `out_last` go to 0 without waiting for a clock; a new single-beat request for index 5 after reset yields 8'h20.
- Loopback: `out_deg` feeds the encoder on every beat of a random sweep/single mix (1000 requests) → encoder result equals `out_idx` on every valid beat; the one-hot invariant is checked each cycle.
